// File: rtl/axis_width_converter.sv
// -----------------------------------------------------------------------------
// axis_width_converter
//
// AXI-Stream data-width converter. The mode is chosen at elaboration from the
// ratio of the two data widths:
//   S_DATA_WIDTH > M_DATA_WIDTH : downsize. Each input word is split into
//                                 M-sized segments. Segments whose keep slice
//                                 is all-zero are skipped.
//   S_DATA_WIDTH < M_DATA_WIDTH : upsize. Input beats are packed into lanes.
//                                 A word closes when it is full or on tlast.
//   S_DATA_WIDTH = M_DATA_WIDTH : register slice with skid, latency 1.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   input_axis_t*              slave stream (tdata/tkeep/tvalid/tready/
//                              tlast/tuser/tid)
//   output_axis_t*             master stream, same field set
// All output fields come straight from registers. In downsize and upsize
// modes, input_axis_tready is a function of state, output_axis_tready and
// rst_n only. It never depends on input_axis_tvalid.
// -----------------------------------------------------------------------------
module axis_width_converter #(
   parameter int S_DATA_WIDTH = 64,
   parameter int M_DATA_WIDTH = 8,
   parameter int S_KEEP_WIDTH = S_DATA_WIDTH / 8,
   parameter int M_KEEP_WIDTH = M_DATA_WIDTH / 8,
   parameter int USER_WIDTH   = 1,
   parameter int ID_WIDTH     = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [S_DATA_WIDTH-1:0] input_axis_tdata,
   input  logic [S_KEEP_WIDTH-1:0] input_axis_tkeep,
   input  logic                    input_axis_tvalid,
   output logic                    input_axis_tready,
   input  logic                    input_axis_tlast,
   input  logic [USER_WIDTH-1:0]   input_axis_tuser,
   input  logic [ID_WIDTH-1:0]     input_axis_tid,
   output logic [M_DATA_WIDTH-1:0] output_axis_tdata,
   output logic [M_KEEP_WIDTH-1:0] output_axis_tkeep,
   output logic                    output_axis_tvalid,
   input  logic                    output_axis_tready,
   output logic                    output_axis_tlast,
   output logic [USER_WIDTH-1:0]   output_axis_tuser,
   output logic [ID_WIDTH-1:0]     output_axis_tid
);

   localparam bit IS_DOWN = S_DATA_WIDTH > M_DATA_WIDTH;
   localparam bit IS_UP   = S_DATA_WIDTH < M_DATA_WIDTH;
   localparam int RATIO   = IS_DOWN ? S_DATA_WIDTH / M_DATA_WIDTH :
                            (IS_UP ? M_DATA_WIDTH / S_DATA_WIDTH : 1);
   localparam bit WIDTH_OK = (S_DATA_WIDTH % 8 == 0) && (M_DATA_WIDTH % 8 == 0) &&
                             (S_KEEP_WIDTH == S_DATA_WIDTH / 8) &&
                             (M_KEEP_WIDTH == M_DATA_WIDTH / 8) &&
                             (IS_DOWN ? (S_DATA_WIDTH % M_DATA_WIDTH == 0)
                                      : (M_DATA_WIDTH % S_DATA_WIDTH == 0));
   localparam int SEG_W = (RATIO > 1) ? $clog2(RATIO) : 1;

   // Output field registers, shared by every mode.
   logic [M_DATA_WIDTH-1:0] out_data_reg;
   logic [M_KEEP_WIDTH-1:0] out_keep_reg;
   logic                    out_last_reg;
   logic [USER_WIDTH-1:0]   out_user_reg;
   logic [ID_WIDTH-1:0]     out_id_reg;
   logic                    out_valid;

   assign output_axis_tdata  = out_data_reg;
   assign output_axis_tkeep  = out_keep_reg;
   assign output_axis_tvalid = out_valid;
   assign output_axis_tlast  = out_last_reg;
   assign output_axis_tuser  = out_user_reg;
   assign output_axis_tid    = out_id_reg;

   // Lowest set index in nz at or above 'from'. Returns 0 when there is none.
   function automatic int lowest_from(input logic [RATIO-1:0] nz, input int from);
      lowest_from = 0;
      for (int i = RATIO - 1; i >= 0; i--) begin
         if (i >= from && nz[i]) lowest_from = i;
      end
   endfunction

   // True when some index strictly above idx is set in nz.
   function automatic logic any_above(input logic [RATIO-1:0] nz, input int idx);
      any_above = 1'b0;
      for (int i = 0; i < RATIO; i++) begin
         if (i > idx && nz[i]) any_above = 1'b1;
      end
   endfunction

   if (!WIDTH_OK) begin : g_bad_widths
      $error("axis_width_converter: data widths must be byte multiples with an integer ratio");
   end else if (IS_DOWN) begin : g_down
      typedef enum logic {IDLE, SPLIT} dn_state_t;
      dn_state_t               state_reg;
      logic [SEG_W-1:0]        seg_reg;
      logic [S_DATA_WIDTH-1:0] data_reg;
      logic [S_KEEP_WIDTH-1:0] keep_reg;
      logic                    last_reg;
      logic [USER_WIDTH-1:0]   user_reg;
      logic                    out_valid_reg;

      // Per-segment "carries at least one byte" flags for the incoming word
      // and for the word being split.
      logic [RATIO-1:0] in_nz;
      logic [RATIO-1:0] reg_nz;
      for (genvar gi = 0; gi < RATIO; gi++) begin : g_nz
         assign in_nz[gi]  = |input_axis_tkeep[gi*M_KEEP_WIDTH +: M_KEEP_WIDTH];
         assign reg_nz[gi] = |keep_reg[gi*M_KEEP_WIDTH +: M_KEEP_WIDTH];
      end

      logic [SEG_W-1:0] in_first;
      logic             in_first_more;
      logic [SEG_W-1:0] nxt_seg;
      logic             cur_more;
      logic             nxt_more;
      always_comb begin
         in_first      = SEG_W'(lowest_from(in_nz, 0));
         in_first_more = any_above(in_nz, int'(in_first));
         nxt_seg       = SEG_W'(lowest_from(reg_nz, int'(seg_reg) + 1));
         cur_more      = any_above(reg_nz, int'(seg_reg));
         nxt_more      = any_above(reg_nz, int'(nxt_seg));
      end

      // The final beat of a word frees the buffer on the same edge it drains,
      // so the next word loads with no bubble.
      assign input_axis_tready = rst_n && ((state_reg == IDLE) ||
                                           (!cur_more && output_axis_tready));
      assign out_valid = out_valid_reg;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            state_reg     <= IDLE;
            seg_reg       <= '0;
            data_reg      <= '0;
            keep_reg      <= '0;
            last_reg      <= 1'b0;
            user_reg      <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_keep_reg  <= '0;
            out_last_reg  <= 1'b0;
            out_user_reg  <= '0;
            out_id_reg    <= '0;
         end else begin
            if (out_valid_reg && output_axis_tready) begin
               if (cur_more) begin
                  seg_reg      <= nxt_seg;
                  out_data_reg <= data_reg[nxt_seg*M_DATA_WIDTH +: M_DATA_WIDTH];
                  out_keep_reg <= keep_reg[nxt_seg*M_KEEP_WIDTH +: M_KEEP_WIDTH];
                  out_last_reg <= last_reg && !nxt_more;
                  out_user_reg <= nxt_more ? '0 : user_reg;
               end else begin
                  state_reg     <= IDLE;
                  out_valid_reg <= 1'b0;
               end
            end
            // A load overrides the drain above when both happen on one edge.
            if (input_axis_tvalid && input_axis_tready) begin
               data_reg   <= input_axis_tdata;
               keep_reg   <= input_axis_tkeep;
               last_reg   <= input_axis_tlast;
               user_reg   <= input_axis_tuser;
               seg_reg    <= in_first;
               out_id_reg <= input_axis_tid;
               if (|input_axis_tkeep) begin
                  state_reg     <= SPLIT;
                  out_valid_reg <= 1'b1;
                  out_data_reg  <= input_axis_tdata[in_first*M_DATA_WIDTH +: M_DATA_WIDTH];
                  out_keep_reg  <= input_axis_tkeep[in_first*M_KEEP_WIDTH +: M_KEEP_WIDTH];
                  out_last_reg  <= input_axis_tlast && !in_first_more;
                  out_user_reg  <= in_first_more ? '0 : input_axis_tuser;
               end else if (input_axis_tlast) begin
                  // An empty closing word still marks the packet boundary.
                  state_reg     <= SPLIT;
                  out_valid_reg <= 1'b1;
                  out_data_reg  <= '0;
                  out_keep_reg  <= '0;
                  out_last_reg  <= 1'b1;
                  out_user_reg  <= input_axis_tuser;
               end else begin
                  state_reg     <= IDLE;
                  out_valid_reg <= 1'b0;
               end
            end
         end
      end
   end else if (IS_UP) begin : g_up
      typedef enum logic {FILL, HOLD} up_state_t;
      up_state_t               state_reg;
      logic [SEG_W-1:0]        cnt_reg;
      logic [M_DATA_WIDTH-1:0] acc_data_reg;
      logic [M_KEEP_WIDTH-1:0] acc_keep_reg;
      logic [USER_WIDTH-1:0]   acc_user_reg;
      logic [ID_WIDTH-1:0]     acc_id_reg;

      // The word as it would look with the current input placed in its lane.
      // The accumulator is cleared on completion, so unfilled lanes stay zero.
      logic [M_DATA_WIDTH-1:0] asm_data;
      logic [M_KEEP_WIDTH-1:0] asm_keep;
      logic [USER_WIDTH-1:0]   asm_user;
      logic [ID_WIDTH-1:0]     asm_id;
      logic                    word_done;
      always_comb begin
         asm_data = acc_data_reg;
         asm_keep = acc_keep_reg;
         asm_data[cnt_reg*S_DATA_WIDTH +: S_DATA_WIDTH] = input_axis_tdata;
         asm_keep[cnt_reg*S_KEEP_WIDTH +: S_KEEP_WIDTH] = input_axis_tkeep;
         asm_user  = acc_user_reg | input_axis_tuser;
         asm_id    = (cnt_reg == '0) ? input_axis_tid : acc_id_reg;
         word_done = (cnt_reg == SEG_W'(RATIO - 1)) || input_axis_tlast;
      end

      // While a word is held, a new lane may fill only as the held word leaves.
      assign input_axis_tready = rst_n && ((state_reg == FILL) || output_axis_tready);
      assign out_valid = (state_reg == HOLD);

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            state_reg    <= FILL;
            cnt_reg      <= '0;
            acc_data_reg <= '0;
            acc_keep_reg <= '0;
            acc_user_reg <= '0;
            acc_id_reg   <= '0;
            out_data_reg <= '0;
            out_keep_reg <= '0;
            out_last_reg <= 1'b0;
            out_user_reg <= '0;
            out_id_reg   <= '0;
         end else begin
            if (state_reg == HOLD && output_axis_tready) begin
               state_reg <= FILL;
            end
            if (input_axis_tvalid && input_axis_tready) begin
               if (word_done) begin
                  state_reg    <= HOLD;
                  out_data_reg <= asm_data;
                  out_keep_reg <= asm_keep;
                  out_last_reg <= input_axis_tlast;
                  out_user_reg <= asm_user;
                  out_id_reg   <= asm_id;
                  cnt_reg      <= '0;
                  acc_data_reg <= '0;
                  acc_keep_reg <= '0;
                  acc_user_reg <= '0;
                  acc_id_reg   <= '0;
               end else begin
                  cnt_reg      <= cnt_reg + SEG_W'(1);
                  acc_data_reg <= asm_data;
                  acc_keep_reg <= asm_keep;
                  acc_user_reg <= asm_user;
                  acc_id_reg   <= asm_id;
               end
            end
         end
      end
   end else begin : g_equal
      localparam int BUS_W = S_DATA_WIDTH + S_KEEP_WIDTH + 1 + USER_WIDTH + ID_WIDTH;
      logic [BUS_W-1:0] in_bus;
      logic [BUS_W-1:0] skid_reg;
      logic             skid_valid_reg;
      logic             out_valid_reg;

      assign in_bus = {input_axis_tdata, input_axis_tkeep, input_axis_tlast,
                       input_axis_tuser, input_axis_tid};
      // Ready is registered. The skid slot absorbs the one beat that can
      // arrive while the output is stalled.
      assign input_axis_tready = rst_n && !skid_valid_reg;
      assign out_valid = out_valid_reg;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            skid_reg       <= '0;
            skid_valid_reg <= 1'b0;
            out_valid_reg  <= 1'b0;
            {out_data_reg, out_keep_reg, out_last_reg, out_user_reg, out_id_reg} <= '0;
         end else if (!out_valid_reg || output_axis_tready) begin
            if (skid_valid_reg) begin
               {out_data_reg, out_keep_reg, out_last_reg, out_user_reg, out_id_reg} <= skid_reg;
               out_valid_reg  <= 1'b1;
               skid_valid_reg <= 1'b0;
            end else if (input_axis_tvalid) begin
               {out_data_reg, out_keep_reg, out_last_reg, out_user_reg, out_id_reg} <= in_bus;
               out_valid_reg <= 1'b1;
            end else begin
               out_valid_reg <= 1'b0;
            end
         end else if (input_axis_tvalid && input_axis_tready) begin
            skid_reg       <= in_bus;
            skid_valid_reg <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_axis_width_converter.sv
`timescale 1ns/1ps
module tb_axis_width_converter;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      logic        user;
      logic [3:0]  id;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // 64 -> 8
   logic [63:0] dn_id = '0;  logic [7:0] dn_ik = '0;  logic dn_iv = 1'b0, dn_ir, dn_il = 1'b0;
   logic        dn_iu = 1'b0; logic [3:0] dn_ii = '0;
   logic [7:0]  dn_od;        logic [0:0] dn_ok;      logic dn_ov, dn_or = 1'b1, dn_ol;
   logic [0:0]  dn_ou;        logic [3:0] dn_oi;
   // 8 -> 64
   logic [7:0]  up_id = '0;   logic [0:0] up_ik = '0; logic up_iv = 1'b0, up_ir, up_il = 1'b0;
   logic        up_iu = 1'b0; logic [3:0] up_ii = '0;
   logic [63:0] up_od;        logic [7:0] up_ok;      logic up_ov, up_or = 1'b1, up_ol;
   logic [0:0]  up_ou;        logic [3:0] up_oi;
   // 32 -> 32
   logic [31:0] eq_id = '0;   logic [3:0] eq_ik = '0; logic eq_iv = 1'b0, eq_ir, eq_il = 1'b0;
   logic        eq_iu = 1'b0; logic [3:0] eq_ii = '0;
   logic [31:0] eq_od;        logic [3:0] eq_ok;      logic eq_ov, eq_or = 1'b1, eq_ol;
   logic [0:0]  eq_ou;        logic [3:0] eq_oi;

   axis_width_converter #(.S_DATA_WIDTH(64), .M_DATA_WIDTH(8)) u_dn (
      .clk(clk), .rst_n(rst_n),
      .input_axis_tdata(dn_id), .input_axis_tkeep(dn_ik), .input_axis_tvalid(dn_iv),
      .input_axis_tready(dn_ir), .input_axis_tlast(dn_il), .input_axis_tuser(dn_iu),
      .input_axis_tid(dn_ii),
      .output_axis_tdata(dn_od), .output_axis_tkeep(dn_ok), .output_axis_tvalid(dn_ov),
      .output_axis_tready(dn_or), .output_axis_tlast(dn_ol), .output_axis_tuser(dn_ou),
      .output_axis_tid(dn_oi));

   axis_width_converter #(.S_DATA_WIDTH(8), .M_DATA_WIDTH(64)) u_up (
      .clk(clk), .rst_n(rst_n),
      .input_axis_tdata(up_id), .input_axis_tkeep(up_ik), .input_axis_tvalid(up_iv),
      .input_axis_tready(up_ir), .input_axis_tlast(up_il), .input_axis_tuser(up_iu),
      .input_axis_tid(up_ii),
      .output_axis_tdata(up_od), .output_axis_tkeep(up_ok), .output_axis_tvalid(up_ov),
      .output_axis_tready(up_or), .output_axis_tlast(up_ol), .output_axis_tuser(up_ou),
      .output_axis_tid(up_oi));

   axis_width_converter #(.S_DATA_WIDTH(32), .M_DATA_WIDTH(32)) u_eq (
      .clk(clk), .rst_n(rst_n),
      .input_axis_tdata(eq_id), .input_axis_tkeep(eq_ik), .input_axis_tvalid(eq_iv),
      .input_axis_tready(eq_ir), .input_axis_tlast(eq_il), .input_axis_tuser(eq_iu),
      .input_axis_tid(eq_ii),
      .output_axis_tdata(eq_od), .output_axis_tkeep(eq_ok), .output_axis_tvalid(eq_ov),
      .output_axis_tready(eq_or), .output_axis_tlast(eq_ol), .output_axis_tuser(eq_ou),
      .output_axis_tid(eq_oi));

   // ---------------- scoreboard state (index 0=dn, 1=up, 2=eq) ----------------
   string nm [3] = '{"dn", "up", "eq"};
   beat_t exp_q [3][$];
   beat_t cap_q [3][$];
   logic  pend [3];
   beat_t hold [3];
   int    hs [3];
   int    first_c [3];
   int    last_c [3];

   // upsize reference accumulator
   logic [63:0] up_d;
   logic [7:0]  up_k;
   logic        up_u;
   logic [3:0]  up_i;
   int          up_n = 0;

   function automatic beat_t mk(input logic [63:0] d, input logic [7:0] k, input logic l,
                                input logic u, input logic [3:0] i);
      beat_t b;
      b.data = d; b.keep = k; b.last = l; b.user = u; b.id = i;
      return b;
   endfunction

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Downsize reference: one byte beat per kept byte, in byte order; the
   // packet's last/user go on the highest kept byte; an empty closing word
   // yields a single empty tlast beat.
   task automatic model_dn(input beat_t b);
      int    idx[$];
      logic  fin;
      for (int s = 0; s < 8; s++) if (b.keep[s]) idx.push_back(s);
      if (idx.size() == 0) begin
         if (b.last) exp_q[0].push_back(mk(64'd0, 8'd0, 1'b1, b.user, b.id));
      end else begin
         for (int j = 0; j < idx.size(); j++) begin
            fin = (j == idx.size() - 1);
            exp_q[0].push_back(mk(64'(b.data[idx[j]*8 +: 8]), 8'd1, b.last && fin,
                                  fin ? b.user : 1'b0, b.id));
         end
      end
   endtask

   // Upsize reference: append bytes; emit when 8 collected or on tlast.
   task automatic model_up(input beat_t b);
      up_d = up_d | (64'(b.data[7:0]) << (8 * up_n));
      up_k = up_k | (8'(b.keep[0]) << up_n);
      up_u = up_u | b.user;
      if (up_n == 0) up_i = b.id;
      up_n++;
      if (up_n == 8 || b.last) begin
         exp_q[1].push_back(mk(up_d, up_k, b.last, up_u, up_i));
         up_d = '0; up_k = '0; up_u = 1'b0; up_i = '0; up_n = 0;
      end
   endtask

   task automatic check_port(input int m, input logic v, input logic r, input beat_t cur);
      beat_t e;
      if (pend[m]) chk({nm[m], "_stall_stable"}, 80'({v, cur}), 80'({1'b1, hold[m]}));
      pend[m] = 1'b0;
      if (v) begin
         if (r) begin
            if (exp_q[m].size() == 0) begin
               checks++; errors++;
               $display("FAIL %s_beat: got %h expected no beat", nm[m], cur);
            end else begin
               e = exp_q[m].pop_front();
               chk({nm[m], "_beat"}, 80'(cur), 80'(e));
            end
            cap_q[m].push_back(cur);
            if (hs[m] == 0) first_c[m] = cyc;
            last_c[m] = cyc;
            hs[m]++;
         end else begin
            pend[m] = 1'b1;
            hold[m] = cur;
         end
      end
   endtask

   // The single compare process: outputs are compared at the falling edge,
   // inputs accepted on the coming rising edge are fed to the model.
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         for (int m = 0; m < 3; m++) begin
            exp_q[m].delete();
            pend[m] = 1'b0;
         end
         up_d = '0; up_k = '0; up_u = 1'b0; up_i = '0; up_n = 0;
      end else begin
         check_port(0, dn_ov, dn_or, mk(64'(dn_od), 8'(dn_ok), dn_ol, dn_ou[0], dn_oi));
         check_port(1, up_ov, up_or, mk(up_od, up_ok, up_ol, up_ou[0], up_oi));
         check_port(2, eq_ov, eq_or, mk(64'(eq_od), 8'(eq_ok), eq_ol, eq_ou[0], eq_oi));
         if (dn_iv && dn_ir) model_dn(mk(dn_id, dn_ik, dn_il, dn_iu, dn_ii));
         if (up_iv && up_ir) model_up(mk(64'(up_id), 8'(up_ik), up_il, up_iu, up_ii));
         if (eq_iv && eq_ir) exp_q[2].push_back(mk(64'(eq_id), 8'(eq_ik), eq_il, eq_iu, eq_ii));
      end
   end

   // Output-ready pattern: 0 = always ready, 1 = toggle, 2 = random.
   int   rdy_mode = 0;
   logic tgl = 1'b0;
   logic rdy_v;
   always @(posedge clk) begin
      #1;
      tgl = ~tgl;
      case (rdy_mode)
         0: rdy_v = 1'b1;
         1: rdy_v = tgl;
         default: rdy_v = 1'($urandom_range(0, 1));
      endcase
      dn_or = rdy_v; up_or = rdy_v; eq_or = rdy_v;
   end

   task automatic timeout_fail(input string name);
      checks++; errors++;
      $display("FAIL %s_timeout: got no handshake expected handshake within budget", name);
   endtask

   task automatic send_dn(input logic [63:0] d, input logic [7:0] k, input logic l,
                          input logic u, input logic [3:0] i);
      int n = 0; logic acc = 1'b0;
      dn_id = d; dn_ik = k; dn_il = l; dn_iu = u; dn_ii = i; dn_iv = 1'b1;
      while (!acc && n < 200) begin
         @(negedge clk); acc = dn_ir;
         @(posedge clk); #1; n++;
      end
      if (!acc) timeout_fail("dn_send");
      dn_iv = 1'b0;
   endtask

   task automatic send_up(input logic [7:0] d, input logic l, input logic u, input logic [3:0] i);
      int n = 0; logic acc = 1'b0;
      up_id = d; up_ik = 1'b1; up_il = l; up_iu = u; up_ii = i; up_iv = 1'b1;
      while (!acc && n < 200) begin
         @(negedge clk); acc = up_ir;
         @(posedge clk); #1; n++;
      end
      if (!acc) timeout_fail("up_send");
      up_iv = 1'b0;
   endtask

   task automatic send_eq(input logic [31:0] d, input logic [3:0] k, input logic l,
                          input logic u, input logic [3:0] i);
      int n = 0; logic acc = 1'b0;
      eq_id = d; eq_ik = k; eq_il = l; eq_iu = u; eq_ii = i; eq_iv = 1'b1;
      while (!acc && n < 200) begin
         @(negedge clk); acc = eq_ir;
         @(posedge clk); #1; n++;
      end
      if (!acc) timeout_fail("eq_send");
      eq_iv = 1'b0;
   endtask

   task automatic drain(input int m);
      int n = 0; logic busy = 1'b1;
      while (busy && n < 300) begin
         busy = (exp_q[m].size() != 0) || (m == 0 ? dn_ov : (m == 1 ? up_ov : eq_ov));
         if (busy) begin @(posedge clk); #1; n++; end
      end
      chk({nm[m], "_drained"}, 80'(busy), 80'(0));
   endtask

   task automatic clear_stats(input int m);
      hs[m] = 0; first_c[m] = 0; last_c[m] = 0;
      cap_q[m].delete();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1);
   end

   logic [7:0] t1b [5] = '{8'hcd, 8'hab, 8'hcd, 8'hab, 8'hcd};

   initial begin
      for (int m = 0; m < 3; m++) begin pend[m] = 1'b0; clear_stats(m); end
      up_d = '0; up_k = '0; up_u = 1'b0; up_i = '0;

      // ---- reset state ----
      repeat (3) @(posedge clk);
      #1;
      chk("rst_dn_outputs", 80'({dn_ov, dn_od, dn_ok, dn_ol, dn_ou, dn_oi}), 80'(0));
      chk("rst_up_outputs", 80'({up_ov, up_od, up_ok, up_ol, up_ou, up_oi}), 80'(0));
      chk("rst_eq_outputs", 80'({eq_ov, eq_od, eq_ok, eq_ol, eq_ou, eq_oi}), 80'(0));
      chk("rst_tready", 80'({dn_ir, up_ir, eq_ir}), 80'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("tready_after_rst", 80'({dn_ir, up_ir, eq_ir}), 80'(3'b111));

      // ---- 64->8, five kept bytes ----
      clear_stats(0);
      send_dn(64'habcdabcdabcdabcd, 8'h1F, 1'b1, 1'b0, 4'h3);
      drain(0);
      chk("t1_count", 80'(hs[0]), 80'(5));
      for (int k = 0; k < 5; k++) begin
         chk("t1_byte", 80'(cap_q[0][k].data), 80'(t1b[k]));
         chk("t1_last", 80'(cap_q[0][k].last), 80'(k == 4));
      end

      // ---- 64->8, null segments skipped ----
      clear_stats(0);
      send_dn(64'h8877665544332211, 8'h81, 1'b1, 1'b1, 4'h5);
      drain(0);
      chk("t2_count", 80'(hs[0]), 80'(2));
      chk("t2_beat0", 80'(cap_q[0][0]), 80'(mk(64'h11, 8'h1, 1'b0, 1'b0, 4'h5)));
      chk("t2_beat1", 80'(cap_q[0][1]), 80'(mk(64'h88, 8'h1, 1'b1, 1'b1, 4'h5)));

      // ---- 64->8, back-to-back words with toggling output ready ----
      clear_stats(0);
      rdy_mode = 1;
      send_dn(64'h0706050403020100, 8'hFF, 1'b0, 1'b0, 4'h1);
      send_dn(64'h0f0e0d0c0b0a0908, 8'hFF, 1'b1, 1'b0, 4'h1);
      drain(0);
      rdy_mode = 0;
      chk("t3_count", 80'(hs[0]), 80'(16));
      for (int k = 0; k < 16; k++) chk("t3_order", 80'(cap_q[0][k].data), 80'(k));

      // ---- 64->8, back-to-back with ready held: no bubble ----
      clear_stats(0);
      send_dn(64'h0706050403020100, 8'hFF, 1'b0, 1'b0, 4'h2);
      send_dn(64'h0f0e0d0c0b0a0908, 8'hFF, 1'b1, 1'b0, 4'h2);
      drain(0);
      chk("t3b_span", 80'(last_c[0] - first_c[0]), 80'(15));

      // ---- 64->8, empty words ----
      clear_stats(0);
      send_dn(64'h1234, 8'h00, 1'b0, 1'b0, 4'h6);
      send_dn(64'h5678, 8'h00, 1'b1, 1'b1, 4'h6);
      drain(0);
      chk("t4_count", 80'(hs[0]), 80'(1));
      chk("t4_beat", 80'(cap_q[0][0]), 80'(mk(64'h0, 8'h0, 1'b1, 1'b1, 4'h6)));

      // ---- 8->64, short packet ----
      clear_stats(1);
      for (int k = 1; k <= 5; k++) send_up(8'(k), k == 5, 1'b0, 4'h7);
      drain(1);
      chk("t5_count", 80'(hs[1]), 80'(1));
      chk("t5_beat", 80'(cap_q[1][0]), 80'(mk(64'h0000000504030201, 8'h1F, 1'b1, 1'b0, 4'h7)));

      // ---- 8->64, reset mid-word then a full packet ----
      clear_stats(1);
      send_up(8'haa, 1'b0, 1'b1, 4'h9);
      send_up(8'hbb, 1'b0, 1'b0, 4'h9);
      send_up(8'hcc, 1'b0, 1'b0, 4'h9);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 8; k++) send_up(8'(8'h11 + k), k == 7, 1'b0, 4'h2);
      drain(1);
      chk("t6_count", 80'(hs[1]), 80'(1));
      chk("t6_beat", 80'(cap_q[1][0]), 80'(mk(64'h1817161514131211, 8'hFF, 1'b1, 1'b0, 4'h2)));

      // ---- 8->64, random output ready, two packets ----
      clear_stats(1);
      rdy_mode = 2;
      for (int k = 0; k < 19; k++) send_up(8'($urandom), k == 10 || k == 18, k == 3, 4'h4);
      drain(1);
      rdy_mode = 0;
      chk("t7_count", 80'(hs[1]), 80'(3));

      // ---- 32->32, latency and random traffic ----
      clear_stats(2);
      send_eq(32'hdeadbeef, 4'hF, 1'b1, 1'b1, 4'hA);
      chk("eq_latency", 80'(eq_ov), 80'(1));
      chk("eq_first", 80'({eq_od, eq_ok, eq_ol, eq_ou, eq_oi}), 80'({32'hdeadbeef, 4'hF, 1'b1, 1'b1, 4'hA}));
      drain(2);
      rdy_mode = 2;
      for (int k = 0; k < 30; k++) begin
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         send_eq($urandom, 4'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
      end
      drain(2);
      rdy_mode = 0;
      chk("eq_count", 80'(hs[2]), 80'(31));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
